// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART transmitter among NUM_REQ byte streams.
// Optional idle-lock release is compiled in with `define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          ena,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  output logic                          timeout_pulse
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      cur_q, cur_d;
  logic [IDX_W-1:0]      last_winner_q, last_winner_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  out_last_q, out_last_d;

  logic                  win_found;
  logic [IDX_W-1:0]      win_idx;
  int                    scan_idx;
  logic                  cur_valid, cur_last;
  logic [DATA_WIDTH-1:0] cur_data;
  logic                  req_xfer, tx_xfer, timeout_hit;

  assign cur_valid = req_valid[cur_q];
  assign cur_last  = req_last[cur_q];
  assign cur_data  = req_data[int'(cur_q)*DATA_WIDTH +: DATA_WIDTH];

  assign req_xfer  = ena & (state_q == LOAD) & cur_valid;
  assign tx_xfer   = ena & tx_valid_q & tx_ready;

  assign req_ready = (reset_n && ena && state_q == LOAD) ? (NUM_REQ'(1) << cur_q) : '0;

  // Rotating priority: the requester just after the previous winner is looked at first.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_winner_q;
    scan_idx  = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = int'(last_winner_q) + k;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      if (!win_found && req_valid[scan_idx[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_idx[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cur_q         <= '0;
      last_winner_q <= IDX_W'(NUM_REQ-1);
      grant_q       <= '0;
      busy_q        <= 1'b0;
      tx_data_q     <= '0;
      tx_valid_q    <= 1'b0;
      out_last_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_q         <= cur_d;
      last_winner_q <= last_winner_d;
      grant_q       <= grant_d;
      busy_q        <= busy_d;
      tx_data_q     <= tx_data_d;
      tx_valid_q    <= tx_valid_d;
      out_last_q    <= out_last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (ena) begin
      unique case (state_q)
        IDLE: if (win_found) state_d = LOAD;
        LOAD: begin
          if (req_xfer)         state_d = SEND;
          else if (timeout_hit) state_d = IDLE;
        end
        SEND: if (tx_xfer) state_d = out_last_q ? IDLE : LOAD;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cur_d         = cur_q;
    last_winner_d = last_winner_q;
    grant_d       = grant_q;
    tx_data_d     = tx_data_q;
    tx_valid_d    = tx_valid_q;
    out_last_d    = out_last_q;
    if (ena) begin
      unique case (state_q)
        IDLE: begin
          if (win_found) begin
            cur_d   = win_idx;
            grant_d = NUM_REQ'(1) << win_idx;
          end
        end
        LOAD: begin
          if (req_xfer) begin
            tx_data_d  = cur_data;
            out_last_d = cur_last;
            tx_valid_d = 1'b1;
          end else if (timeout_hit) begin
            grant_d       = '0;
            last_winner_d = cur_q;
          end
        end
        SEND: begin
          if (tx_xfer) begin
            tx_valid_d = 1'b0;
            if (out_last_q) begin
              last_winner_d = cur_q;
              grant_d       = '0;
            end
          end
        end
        default: ;
      endcase
    end
    busy_d = |grant_d;
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign grant    = grant_q;
  assign busy     = busy_q;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_pulse_q, timeout_pulse_d;

  assign timeout_hit = ena & (state_q == LOAD) & ~cur_valid
                     & (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES-1));

  // Counts only stalled LOAD cycles; any other state rearms it for the next LOAD entry.
  always_comb begin
    tmo_cnt_d       = tmo_cnt_q;
    timeout_pulse_d = timeout_pulse_q;
    if (ena) begin
      timeout_pulse_d = timeout_hit;
      if (state_q != LOAD)  tmo_cnt_d = '0;
      else if (timeout_hit) tmo_cnt_d = '0;
      else if (!cur_valid)  tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tmo_cnt_q       <= '0;
      timeout_pulse_q <= 1'b0;
    end else begin
      tmo_cnt_q       <= tmo_cnt_d;
      timeout_pulse_q <= timeout_pulse_d;
    end
  end

  assign timeout_pulse = timeout_pulse_q;
`else
  assign timeout_hit   = 1'b0;
  assign timeout_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (4 requesters, 8-bit bytes, 16-cycle timeout).
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           ena;
  logic [NR-1:0]  req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]  req_last;
  logic [NR-1:0]  req_ready;
  logic [DW-1:0]  tx_data;
  logic           tx_valid;
  logic           tx_ready;
  logic [NR-1:0]  grant;
  logic           busy;
  logic           timeout_pulse;

  int testsRun    = 0;
  int testsFailed = 0;

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n), .ena(ena),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .grant(grant), .busy(busy), .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic setReq(input int i, input logic v, input logic [DW-1:0] d, input logic l);
    req_valid[i]          = v;
    req_data[i*DW +: DW]  = d;
    req_last[i]           = l;
  endtask

  task automatic applyStimulus();
    reset_n   = 1'b0;
    ena       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_ready  = 1'b1;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  logic [DW-1:0] got[5];
  int            nGot;
  int            idx;
  logic          xfer1;
  logic          seenReady;
  logic          seenPulse;
  logic [DW-1:0] rrExp[5];
  logic [DW-1:0] pkExp[4];

  initial begin
    rrExp = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
    pkExp = '{8'h10, 8'h11, 8'h12, 8'h20};

    // Reset state
    applyStimulus();
    checkOutput("rstGrant", grant, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstTxValid", tx_valid, 0);
    checkOutput("rstTxData", tx_data, 0);
    checkOutput("rstReqReady", req_ready, 0);
    checkOutput("rstPulse", timeout_pulse, 0);

    // Single-byte packet from requester 0
    setReq(0, 1'b1, 8'h41, 1'b1);
    tick();
    checkOutput("t1Grant", grant, 4'b0001);
    checkOutput("t1Busy", busy, 1);
    checkOutput("t1TxValidLoad", tx_valid, 0);
    checkOutput("t1ReqReady", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    checkOutput("t1TxValid", tx_valid, 1);
    checkOutput("t1TxData", tx_data, 8'h41);
    tick();
    checkOutput("t1GrantRel", grant, 0);
    checkOutput("t1BusyRel", busy, 0);
    checkOutput("t1TxValidRel", tx_valid, 0);

    // Round robin with everyone continuously valid
    applyStimulus();
    for (int i = 0; i < NR; i++) setReq(i, 1'b1, 8'(8'hA0 + i), 1'b1);
    nGot = 0;
    for (int i = 0; i < 5; i++) got[i] = '0;
    for (int cyc = 0; cyc < 40 && nGot < 5; cyc++) begin
      tick();
      if (tx_valid) begin
        got[nGot] = tx_data;
        nGot++;
      end
    end
    checkOutput("rrCount", nGot, 5);
    for (int i = 0; i < 5; i++) checkOutput($sformatf("rrByte%0d", i), got[i], rrExp[i]);

    // Packet lock: requester 1 three-byte packet while requester 2 waits
    applyStimulus();
    setReq(1, 1'b1, 8'h10, 1'b0);
    setReq(2, 1'b1, 8'h20, 1'b1);
    idx  = 0;
    nGot = 0;
    for (int i = 0; i < 5; i++) got[i] = '0;
    for (int cyc = 0; cyc < 40 && nGot < 4; cyc++) begin
      #1;
      xfer1 = req_valid[1] & req_ready[1];
      tick();
      if (tx_valid) begin
        got[nGot] = tx_data;
        nGot++;
      end
      if (xfer1) begin
        idx++;
        if (idx == 3) req_valid[1] = 1'b0;
        else setReq(1, 1'b1, 8'(8'h10 + idx), idx == 2);
      end
    end
    checkOutput("pkCount", nGot, 4);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("pkByte%0d", i), got[i], pkExp[i]);

    // Transmitter stall and clock-enable freeze mid-packet
    applyStimulus();
    tx_ready = 1'b0;
    setReq(0, 1'b1, 8'h55, 1'b0);
    tick();
    tick();
    setReq(0, 1'b1, 8'h56, 1'b0);
    seenReady = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      seenReady = seenReady | (|req_ready);
    end
    checkOutput("stallReqReady", seenReady, 0);
    checkOutput("stallTxValid", tx_valid, 1);
    checkOutput("stallTxData", tx_data, 8'h55);
    ena      = 1'b0;
    tx_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      seenReady = seenReady | (|req_ready);
    end
    checkOutput("enaReqReady", seenReady, 0);
    checkOutput("enaTxValid", tx_valid, 1);
    checkOutput("enaTxData", tx_data, 8'h55);
    checkOutput("enaGrant", grant, 4'b0001);
    ena = 1'b1;
    tick();
    checkOutput("resumeTxValid", tx_valid, 0);
    checkOutput("resumeReqReady", req_ready, 4'b0001);
    tick();
    tx_ready = 1'b0;
    setReq(0, 1'b1, 8'h57, 1'b1);
    checkOutput("resumeTxData", tx_data, 8'h56);

    // Reset while a byte is waiting in SEND
    reset_n = 1'b0;
    tick();
    checkOutput("midRstTxValid", tx_valid, 0);
    checkOutput("midRstGrant", grant, 0);
    checkOutput("midRstBusy", busy, 0);
    reset_n  = 1'b1;
    tx_ready = 1'b1;
    setReq(0, 1'b1, 8'h60, 1'b1);
    setReq(3, 1'b1, 8'h63, 1'b1);
    tick();
    checkOutput("postRstGrant", grant, 4'b0001);
    tick();
    checkOutput("postRstTxData", tx_data, 8'h60);

    // Requester 3 stalls after its first non-last byte
    applyStimulus();
    setReq(3, 1'b1, 8'h33, 1'b0);
    tick();
    checkOutput("tmoGrant", grant, 4'b1000);
    tick();
    checkOutput("tmoTxData", tx_data, 8'h33);
    req_valid = '0;
    setReq(0, 1'b1, 8'h70, 1'b1);
    tick();
    seenPulse = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      seenPulse = seenPulse | timeout_pulse;
    end
    checkOutput("tmoNoEarlyPulse", seenPulse, 0);
    checkOutput("tmoHeldGrant", grant, 4'b1000);
    tick();
`ifdef UART_ARB_TIMEOUT_EN
    checkOutput("tmoPulse", timeout_pulse, 1);
    checkOutput("tmoRelGrant", grant, 0);
    tick();
    checkOutput("tmoPulseOnce", timeout_pulse, 0);
    checkOutput("tmoNextGrant", grant, 4'b0001);
`else
    checkOutput("noTmoPulse", timeout_pulse, 0);
    checkOutput("noTmoGrant", grant, 4'b1000);
    tick();
    checkOutput("noTmoGrantLater", grant, 4'b1000);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart transmitter between NUM_REQ byte-stream requesters.
- Uses round-robin arbitration with packet lock: the grant is held from a requester's first byte through the byte flagged req_last.
- Sits between the requester logic (status reporter, command echo, debug dump) and the uart transmitter's tx_data/tx_valid/tx_ready port.
- All outputs are registered except req_ready.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- DATA_WIDTH, 8, byte width; matches the transmitter.
- TIMEOUT_CYCLES, 1024, idle-lock limit in clk cycles; used only with UART_ARB_TIMEOUT_EN.

Ports:
- clk  input  1  clock.
- reset_n  input  1  reset.
- ena  input  1  global clock enable; when low, all state is frozen.
- req_valid  input  NUM_REQ  per-requester byte valid.
- req_data  input  NUM_REQ*DATA_WIDTH  per-requester byte; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  input  NUM_REQ  marks the final byte of a packet.
- req_ready  output  NUM_REQ  one-hot byte-accept strobe, combinational.
- tx_data  output  DATA_WIDTH  byte to the transmitter.
- tx_valid  output  1  byte valid to the transmitter.
- tx_ready  input  1  transmitter ready.
- grant  output  NUM_REQ  one-hot current owner; all zero when idle.
- busy  output  1  high whenever grant is nonzero.
- timeout_pulse  output  1  one-cycle pulse on forced release; tied 0 without the macro.

Behaviour:
- Reset: reset_n is synchronous, active-low; clock is clk. Reset wins over ena.
- Reset values: tx_valid=0, tx_data=0, grant=0, busy=0, req_ready=0, timeout_pulse=0, state=IDLE, last_winner=NUM_REQ-1 (so requester 0 has first priority).
- Reset mid-packet: the in-flight byte is discarded, tx_valid drops the next edge, and the lock is released.
- ena low: no state, counter or output register changes; req_ready is forced 0.
- Transfers: a requester transfer is ena & req_valid[i] & req_ready[i]. A downstream transfer is ena & tx_valid & tx_ready.
- State IDLE:
  - If any req_valid is set, select the winner by scanning indices last_winner+1, +2, ... modulo NUM_REQ; the first valid one wins.
  - Set cur and grant, then go to LOAD. Arbitration costs 1 cycle.
- State LOAD:
  - req_ready[cur] = ena; all other req_ready bits are 0.
  - On a requester transfer, capture tx_data <= req_data[cur] and out_last <= req_last[cur], set tx_valid <= 1, and go to SEND.
  - If req_valid[cur] is low, stay in LOAD with the lock held; other requesters wait.
- State SEND:
  - tx_valid stays 1 and tx_data stays stable until a downstream transfer.
  - On the downstream transfer, tx_valid <= 0.
  - If out_last is set: last_winner <= cur, grant <= 0, go to IDLE.
  - Otherwise: go to LOAD for the next byte of the same packet.
- Latency: a byte presented in LOAD appears on tx_valid 1 cycle later. Minimum spacing between packets from different requesters is 2 cycles (SEND→IDLE→LOAD).
- req_valid from a non-granted requester is ignored mid-packet, with no effect on grant.
- A single-byte packet (req_last=1 on the first byte) releases the lock after that byte.
- If all requesters are continuously valid with single-byte packets, grant order is 0,1,2,3,0,…

Optional Feature:
UART_ARB_TIMEOUT_EN
- Defined:
  - A counter clears on entry to LOAD and increments in LOAD while req_valid[cur]=0 and ena=1.
  - When the counter reaches TIMEOUT_CYCLES-1, the block forces release: grant <= 0, last_winner <= cur, state <= IDLE, timeout_pulse=1 for one cycle.
  - SEND is never timed out.
- Undefined: no counter is instantiated, timeout_pulse is constant 0, and the lock is held indefinitely.

Test Plan:
- Reset, then req_valid=0001 with data 0x41 and last=1, tx_ready=1: grant=0001 one cycle after valid; tx_valid=1 and tx_data=0x41 one cycle later; grant=0 after the downstream transfer.
- All four requesters hold valid with single-byte packets 0xA0..0xA3: the transmitter receives 0xA0, 0xA1, 0xA2, 0xA3, 0xA0 in order.
- Requester 1 sends a 3-byte packet 0x10, 0x11, 0x12 (last on 0x12) while requester 2 is valid throughout: all three bytes go out before any byte from requester 2.
- Hold tx_ready=0 for 20 cycles during SEND: tx_valid and tx_data stay stable and req_ready stays all-zero. Toggle ena low for 5 cycles mid-packet: no output changes.
- Assert reset_n=0 in SEND mid-packet: the next edge gives tx_valid=0 and grant=0. After release, a requester-0 request wins first.
- With UART_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, requester 3 drops valid after its first non-last byte: timeout_pulse is asserted 16 LOAD cycles later, then requester 0 is granted. Without the macro, grant stays 1000.
